perf_commit_event_collector: RTL and testbench
==============================================

# perf_commit_event_collector

Upstream feeder for the machine performance-counter file. It decodes instruction-class events (load, store, branch/jump, call, return) across all commit ports in the same cycle, so that simultaneous commits are never lost. Events accumulate in small per-event pending counters. Each counter drains as at most one increment pulse per cycle into the counter file's single-step increment inputs. It sits between the commit stage and the perf counter file, next to the CSR write path that clears it.

## Interface

Parameters:
- NrCommitPorts, default ariane_pkg::NR_COMMIT_PORTS: number of commit ports decoded.
- PendWidth, default 4: width of each per-event pending counter; saturates at 2^PendWidth-1.

Ports:
- clk_i  input  1  core clock; the only clock.
- rst_ni  input  1  asynchronous, active-low reset.
- debug_mode_i  input  1  when high, no new events are accepted; draining continues.
- commit_instr_i  input  scoreboard_entry_t[NrCommitPorts]  instructions presented by the commit stage.
- commit_ack_i  input  NrCommitPorts  per-port commit acknowledge.
- clear_i  input  5  per-event clear, pulsed on a CSR write to the matching counter.
- inc_o  output  5  per-event increment pulse to the counter file.
- drop_o  output  5  sticky per-event flag: at least one event was lost to saturation.

Event index, used for all 5-bit vectors:
- 0 load
- 1 store
- 2 branch_jump
- 3 call
- 4 ret

## Operation

- Per-port event decode is qualified by commit_ack_i[p]. Ports without an ack contribute nothing.
  - load: fu==LOAD.
  - store: fu==STORE.
  - branch_jump: fu==CTRL_FLOW.
  - call: fu==CTRL_FLOW, op==ADD (JAL) or op==JALR, and rd in {x1, x5}.
  - ret: op==JALR, rs1 in {x1, x5}, and rd not in {x1, x5}.
  - One instruction may raise several events (for example branch_jump plus call).
- n[e] is the popcount of event e over all ports, range 0..NrCommitPorts. n[e] is forced to 0 while debug_mode_i is high.
- State per event:
  - pend[e], PendWidth bits.
  - drop[e], 1 bit.
- Output relations:
  - inc_o[e] = (pend[e] != 0), decoded only from the pend register.
  - drop_o[e] = drop[e].
- Update each cycle for event e:
  - If clear_i[e]: pend <- 0 and drop <- 0. Any n[e] in the same cycle is discarded.
  - Otherwise, compute sum = pend - inc_o[e] + n[e] at width PendWidth+2, with no wrap.
    - If sum > 2^PendWidth-1: pend <- 2^PendWidth-1 and drop <- 1.
    - Otherwise: pend <- sum.
- Events are independent. No arbitration between them is needed.

## Timing

- Reset (asynchronous, rst_ni low): all pend = 0, all drop = 0, so inc_o = 0 and drop_o = 0. This takes effect immediately and holds mid-stream; all pending events are discarded.
- Latency: an event committed in cycle t is visible as an inc_o pulse in cycle t+1 at the earliest.
- Throughput: one inc_o pulse per event per cycle. k events committed together produce inc_o high for k consecutive cycles, provided no further events arrive.
- Steady state: n[e]==1 every cycle keeps pend[e] at 1 and inc_o[e] high continuously, with no growth.
- Empty boundary: pend==0 and n==0 gives inc_o low in the next cycle; there is no underflow.
- Full boundary:
  - pend = 2^PendWidth-1 with n==1 holds pend at max (drain of 1 and add of 1 cancel), and drop is not set.
  - n==2 at max sets drop.
- debug_mode_i: when it rises, accepted events stop in that cycle. Already-pending events keep draining, so inc_o may stay high for up to 2^PendWidth-1 cycles into debug mode.
- clear_i: pend is 0 in cycle t+1, so inc_o[e] is low in t+1. The increment pulse shown in the clear cycle itself is allowed; the counter-file write has priority over increment in that cycle.

## Test plan

- Reset, then 2 ports both ack LOAD in cycle 0 -> inc_o[0] high in cycles 1 and 2, low in cycle 3; inc_o[1..4] stay 0.
- Port0 acks JAL rd=x1 and port1 acks JALR rs1=x1 rd=x0 in the same cycle -> inc_o[2] high for 2 cycles; inc_o[3] and inc_o[4] each high for 1 cycle.
- PendWidth=4, two STOREs every cycle for 20 cycles -> pend[1] saturates at 15, drop_o[1]=1 and stays 1. After input stops, inc_o[1] is high for exactly 15 further cycles.
- Pend[0]=5, then pulse clear_i[0] together with a new LOAD commit -> inc_o[0]=0 and drop_o[0]=0 in the next cycle; the new LOAD is not counted.
- debug_mode_i high with pend[2]=3 while branches commit each cycle -> exactly 3 more inc_o[2] pulses, then 0.
- Assert rst_ni low mid-drain with pend=7 -> inc_o and drop_o are 0 immediately (asynchronously); after release, no residual pulses.

Source files
------------

// File: rtl/perf_commit_event_collector.sv
// Commit-stage performance event collector: decodes per-port instruction-class events,
// buffers them in saturating pending counters and drains one increment pulse per event per cycle.

package ariane_pkg;
  // Minimal stand-in for the core package: only the commit-entry fields the collector decodes.
  localparam int unsigned NR_COMMIT_PORTS = 2;

  typedef enum logic [3:0] {
    NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR
  } fu_t;

  typedef enum logic [6:0] {
    ADD, SUB, JALR, EQ, NE, LW, SW
  } fu_op;

  typedef struct packed {
    fu_t        fu;
    fu_op       op;
    logic [4:0] rs1;
    logic [4:0] rd;
  } scoreboard_entry_t;
endpackage

module perf_commit_event_collector
  import ariane_pkg::*;
#(
  parameter int unsigned NrCommitPorts = ariane_pkg::NR_COMMIT_PORTS,
  parameter int unsigned PendWidth     = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  debug_mode_i,
  input  scoreboard_entry_t [NrCommitPorts-1:0] commit_instr_i,
  input  logic              [NrCommitPorts-1:0] commit_ack_i,
  input  logic              [4:0]               clear_i,
  output logic              [4:0]               inc_o,
  output logic              [4:0]               drop_o
);

  localparam int unsigned NrEvents = 5;
  localparam int unsigned CntWidth = $clog2(NrCommitPorts + 1);
  localparam int unsigned SumWidth = PendWidth + 2;
  localparam logic [PendWidth-1:0] PendMax = '1;

  localparam int unsigned EvLoad   = 0;
  localparam int unsigned EvStore  = 1;
  localparam int unsigned EvBranch = 2;
  localparam int unsigned EvCall   = 3;
  localparam int unsigned EvRet    = 4;

  logic [PendWidth-1:0] pend_q [NrEvents];
  logic [PendWidth-1:0] pend_d [NrEvents];
  logic [NrEvents-1:0]  drop_q;
  logic [NrEvents-1:0]  drop_d;
  logic [CntWidth-1:0]  n      [NrEvents];

  // x1 (ra) and x5 (t0) are the link registers of the RISC-V return-address-stack hints.
  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic logic [NrEvents-1:0] decode(input scoreboard_entry_t instr);
    logic [NrEvents-1:0] ev;
    ev           = '0;
    ev[EvLoad]   = (instr.fu == LOAD);
    ev[EvStore]  = (instr.fu == STORE);
    ev[EvBranch] = (instr.fu == CTRL_FLOW);
    ev[EvCall]   = (instr.fu == CTRL_FLOW) && ((instr.op == ADD) || (instr.op == JALR))
                   && is_link(instr.rd);
    ev[EvRet]    = (instr.op == JALR) && is_link(instr.rs1) && !is_link(instr.rd);
    return ev;
  endfunction

  // Per-event popcount over all acknowledged ports; nothing is accepted in debug mode.
  always_comb begin
    logic [NrEvents-1:0] ev;
    // NOTE: every comb output gets a default before any conditional update, so no latch is inferred.
    for (int e = 0; e < NrEvents; e++) n[e] = '0;
    for (int p = 0; p < NrCommitPorts; p++) begin
      ev = decode(commit_instr_i[p]);
      for (int e = 0; e < NrEvents; e++) begin
        if (commit_ack_i[p] && ev[e] && !debug_mode_i) n[e] = n[e] + CntWidth'(1);
      end
    end
  end

  always_comb begin
    for (int e = 0; e < NrEvents; e++) inc_o[e] = (pend_q[e] != '0);
  end

  assign drop_o = drop_q;

  // Drain one, add n, saturate at PendMax; a CSR clear overrides both and discards n.
  always_comb begin
    logic [SumWidth-1:0] sum;
    drop_d = drop_q;
    sum    = '0;
    for (int e = 0; e < NrEvents; e++) begin
      pend_d[e] = pend_q[e];
      if (clear_i[e]) begin
        pend_d[e] = '0;
        drop_d[e] = 1'b0;
      end else begin
        sum = {2'b00, pend_q[e]} - SumWidth'(inc_o[e]) + SumWidth'(n[e]);
        if (sum > {2'b00, PendMax}) begin
          pend_d[e] = PendMax;
          drop_d[e] = 1'b1;
        end else begin
          pend_d[e] = sum[PendWidth-1:0];
        end
      end
    end
  end

  // NOTE: the pending counters are a handful of flops, not a RAM, so they are reset like any other state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int e = 0; e < NrEvents; e++) pend_q[e] <= '0;
      drop_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      for (int e = 0; e < NrEvents; e++) pend_q[e] <= pend_d[e];
      drop_q <= drop_d;
    end
  end

endmodule

// File: tb/tb_perf_commit_event_collector.sv
// Directed self-checking bench for perf_commit_event_collector (2 commit ports, PendWidth 4).

module tb_perf_commit_event_collector;
  import ariane_pkg::*;

  localparam int unsigned NrPorts = 2;

  logic                            clk_i = 1'b0;
  logic                            rst_ni;
  logic                            debug_mode_i;
  scoreboard_entry_t [NrPorts-1:0] commit_instr_i;
  logic              [NrPorts-1:0] commit_ack_i;
  logic              [4:0]         clear_i;
  logic              [4:0]         inc_o;
  logic              [4:0]         drop_o;

  int checks = 0;
  int errors = 0;
  int cnt;

  perf_commit_event_collector #(
    .NrCommitPorts(NrPorts),
    .PendWidth    (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .debug_mode_i  (debug_mode_i),
    .commit_instr_i(commit_instr_i),
    .commit_ack_i  (commit_ack_i),
    .clear_i       (clear_i),
    .inc_o         (inc_o),
    .drop_o        (drop_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic scoreboard_entry_t mk(input fu_t fu, input fu_op op,
                                           input logic [4:0] rs1, input logic [4:0] rd);
    scoreboard_entry_t s;
    s.fu  = fu;
    s.op  = op;
    s.rs1 = rs1;
    s.rd  = rd;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input scoreboard_entry_t i0, input logic a0,
                       input scoreboard_entry_t i1, input logic a1);
    commit_instr_i[0] = i0;
    commit_instr_i[1] = i1;
    commit_ack_i      = {a1, a0};
  endtask

  task automatic idle();
    drive(mk(NONE, ADD, 5'd0, 5'd0), 1'b0, mk(NONE, ADD, 5'd0, 5'd0), 1'b0);
  endtask

  // Counts cycles with inc_o[idx] high over a bounded window, starting with the current cycle.
  task automatic count_inc(input int idx, input int budget, output int c);
    c = 0;
    repeat (budget) begin
      if (inc_o[idx]) c++;
      tick();
    end
  endtask

  scoreboard_entry_t ld, st, br, jal_ra, jalr_ret;

  initial begin
    ld       = mk(LOAD, LW, 5'd2, 5'd10);
    st       = mk(STORE, SW, 5'd2, 5'd0);
    br       = mk(CTRL_FLOW, EQ, 5'd3, 5'd0);
    jal_ra   = mk(CTRL_FLOW, ADD, 5'd0, 5'd1);
    jalr_ret = mk(CTRL_FLOW, JALR, 5'd1, 5'd0);

    rst_ni       = 1'b0;
    debug_mode_i = 1'b0;
    clear_i      = '0;
    idle();
    #12;
    check("reset_inc", inc_o, 5'b00000);
    check("reset_drop", drop_o, 5'b00000);
    tick();
    rst_ni = 1'b1;
    tick();

    // Two loads together drain as two consecutive pulses.
    drive(ld, 1'b1, ld, 1'b1);
    tick();
    idle();
    check("load_c1", inc_o, 5'b00001);
    tick();
    check("load_c2", inc_o, 5'b00001);
    tick();
    check("load_c3", inc_o, 5'b00000);

    // JAL ra plus a return in one cycle: two branch pulses, one call, one ret.
    drive(jal_ra, 1'b1, jalr_ret, 1'b1);
    tick();
    idle();
    check("callret_c1", inc_o, 5'b11100);
    tick();
    check("callret_c2", inc_o, 5'b00100);
    tick();
    check("callret_c3", inc_o, 5'b00000);

    // Unacknowledged ports contribute nothing.
    drive(ld, 1'b0, st, 1'b0);
    tick();
    idle();
    check("no_ack", inc_o, 5'b00000);

    // Two stores per cycle for 20 cycles saturates pend[1] at 15 and sets drop.
    drive(st, 1'b1, st, 1'b1);
    repeat (20) tick();
    idle();
    check("sat_inc", inc_o, 5'b00010);
    check("sat_drop", drop_o, 5'b00010);
    count_inc(1, 40, cnt);
    check("sat_drain_len", cnt, 15);
    check("sat_drop_sticky", drop_o, 5'b00010);
    clear_i = 5'b00010;
    tick();
    clear_i = '0;
    check("drop_cleared", drop_o, 5'b00000);

    // Build pend[0]=5, then clear together with a new load commit.
    drive(ld, 1'b1, ld, 1'b1);
    repeat (4) tick();
    check("pend5_inc", inc_o, 5'b00001);
    clear_i = 5'b00001;
    tick();
    clear_i = '0;
    idle();
    check("clr_inc", inc_o, 5'b00000);
    check("clr_drop", drop_o, 5'b00000);
    tick();
    check("clr_discards_new", inc_o, 5'b00000);

    // Reach max without overflow, then n==1 at max holds pend and leaves drop clear.
    drive(ld, 1'b1, ld, 1'b1);
    repeat (14) tick();
    drive(ld, 1'b1, st, 1'b0);
    repeat (5) tick();
    idle();
    check("max_n1_drop", drop_o, 5'b00000);
    count_inc(0, 40, cnt);
    check("max_n1_hold_len", cnt, 15);

    // Debug mode with pend[2]=3 and branches still committing: exactly 3 pulses.
    drive(br, 1'b1, br, 1'b1);
    repeat (2) tick();
    debug_mode_i = 1'b1;
    count_inc(2, 20, cnt);
    check("debug_drain_len", cnt, 3);
    check("debug_end_inc", inc_o, 5'b00000);
    debug_mode_i = 1'b0;
    idle();

    // Asynchronous reset mid-drain with pend[0]=7 and drop[1] set.
    drive(st, 1'b1, st, 1'b1);
    repeat (16) tick();
    drive(ld, 1'b1, ld, 1'b1);
    repeat (6) tick();
    idle();
    check("pre_rst_inc", inc_o, 5'b00011);
    check("pre_rst_drop", drop_o, 5'b00010);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_inc", inc_o, 5'b00000);
    check("async_rst_drop", drop_o, 5'b00000);
    tick();
    rst_ni = 1'b1;
    cnt = 0;
    repeat (10) begin
      if (inc_o != 5'b00000) cnt++;
      tick();
    end
    check("post_rst_residual", cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
